// File: rtl/mips_bus_arbiter.sv
// Two-requester (fetch/data) Avalon-MM master arbiter with little-endian byte-lane steering.
// Optional waitrequest timeout abort is compiled in with `define MIPS_BUS_TIMEOUT_EN.
`timescale 1ns/1ps
module mips_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        busy,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic        last_data_q, last_data_d;
  logic        gnt_data_q, gnt_data_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

`ifdef MIPS_BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
`endif

  logic        pick_data;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic        sel_mis;
  logic [3:0]  lane_be;
  logic [31:0] lane_wd;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;

  // Round-robin: on a tie, data wins unless it was the last one granted.
  always_comb begin
    pick_data = d_req && (!if_req || !last_data_q);
    sel_addr  = pick_data ? d_addr : if_addr;
    sel_size  = pick_data ? d_size : 2'b10;
    case (sel_size)
      2'b00:   sel_mis = 1'b0;
      2'b01:   sel_mis = sel_addr[0];
      2'b10:   sel_mis = |sel_addr[1:0];
      default: sel_mis = 1'b1;
    endcase
  end

  always_comb begin
    rd_shift = readdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00: begin
        lane_be  = 4'b0001 << addr_q[1:0];
        lane_wd  = {4{wdata_q[7:0]}};
        load_ext = signed_q ? {{24{rd_shift[7]}}, rd_shift[7:0]} : {24'b0, rd_shift[7:0]};
      end
      2'b01: begin
        lane_be  = 4'b0011 << addr_q[1:0];
        lane_wd  = {2{wdata_q[15:0]}};
        load_ext = signed_q ? {{16{rd_shift[15]}}, rd_shift[15:0]} : {16'b0, rd_shift[15:0]};
      end
      default: begin
        lane_be  = 4'b1111;
        lane_wd  = wdata_q;
        load_ext = readdata;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    gnt_data_d  = gnt_data_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef MIPS_BUS_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    case (state_q)
      StIdle: begin
`ifdef MIPS_BUS_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        if (if_req || d_req) begin
          gnt_data_d  = pick_data;
          last_data_d = pick_data;
          we_d        = pick_data & d_we;
          size_d      = sel_size;
          signed_d    = pick_data & d_signed;
          addr_d      = sel_addr;
          wdata_d     = pick_data ? d_wdata : 32'b0;
          err_d       = sel_mis;
          if (sel_mis) begin
            // No bus cycle for misaligned requests; answer immediately with zero data.
            if (pick_data) d_rdata_d = 32'b0;
            else           if_rdata_d = 32'b0;
            state_d = StDone;
          end else begin
            state_d = StAccess;
          end
        end
      end

      StAccess: begin
        if (!waitrequest) begin
          if (gnt_data_q) d_rdata_d = we_q ? 32'b0 : load_ext;
          else            if_rdata_d = readdata;
          state_d = StDone;
        end
`ifdef MIPS_BUS_TIMEOUT_EN
        else if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          err_d = 1'b1;
          if (gnt_data_q) d_rdata_d = 32'b0;
          else            if_rdata_d = 32'b0;
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end

      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      last_data_q <= 1'b0;
      gnt_data_q  <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      addr_q      <= 32'b0;
      wdata_q     <= 32'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= 32'b0;
      d_rdata_q   <= 32'b0;
`ifdef MIPS_BUS_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      gnt_data_q  <= gnt_data_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MIPS_BUS_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  // Bus outputs are forced to zero outside ACCESS so idle cycles look like reset.
  always_comb begin
    address    = 32'b0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = 32'b0;
    byteenable = 4'b0000;
    if (state_q == StAccess) begin
      address    = {addr_q[31:2], 2'b00};
      read       = !we_q;
      write      = we_q;
      byteenable = lane_be;
      writedata  = we_q ? lane_wd : 32'b0;
    end
  end

  assign if_ack   = (state_q == StDone) && !gnt_data_q;
  assign d_ack    = (state_q == StDone) && gnt_data_q;
  assign err      = (state_q == StDone) && err_q;
  assign busy     = (state_q != StIdle);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: byte-array memory model, random stalls and requests.
`timescale 1ns/1ps
module tb_mips_bus_arbiter;
`ifdef MIPS_BUS_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 1023;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic if_req = 0, d_req = 0, d_we = 0, d_signed = 0, waitrequest = 0;
  logic [1:0] d_size = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, readdata = 0;
  logic if_ack, d_ack, err, busy, read, write;
  logic [31:0] if_rdata, d_rdata, address, writedata;
  logic [3:0] byteenable;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .busy(busy), .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data, mis, tmo, we;
    int          grant;
    logic [31:0] exp_addr, exp_wd, exp_rdata;
    logic [3:0]  exp_be;
  } entry_t;

  entry_t      sb[$];
  logic [7:0]  mmem[64];
  logic [31:0] smem[16];
  int cyc = 0, n_tests = 0, n_fail = 0, n_acks = 0, last_ack = 0, stalls = 0, cur_st = 0;
  int stall_n = 0;
  bit last_d_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference transaction from the byte-level memory view.
  function automatic entry_t model_xact(bit is_d, bit we, logic [1:0] size, bit sgn,
                                        logic [31:0] addr, logic [31:0] wdata);
    entry_t e;
    int n, base;
    logic [31:0] val;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base = int'(addr % 64);
    e.is_data = is_d; e.we = we; e.tmo = 0; e.grant = -1;
    e.mis = (size == 2'd3) || ((addr % n) != 0);
    e.exp_addr = addr & 32'hFFFF_FFFC;
    e.exp_be = 4'(((1 << n) - 1) << (addr % 4));
    e.exp_wd = 0; e.exp_rdata = 0;
    if (!e.mis) begin
      if (we) begin
        for (int l = 0; l < 4; l++) e.exp_wd[8*l +: 8] = 8'(wdata >> (8 * (l % n)));
        for (int i = 0; i < n; i++) mmem[base + i] = 8'(wdata >> (8 * i));
      end else begin
        val = 0;
        for (int i = 0; i < n; i++) val = val | (32'(mmem[base + i]) << (8 * i));
        if (sgn && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
        e.exp_rdata = val;
      end
    end
    return e;
  endfunction

  task automatic poke(input int w, input logic [31:0] v);
    smem[w] = v;
    for (int k = 0; k < 4; k++) mmem[4*w + k] = 8'(v >> (8 * k));
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic run(input int target);
    int budget = 0;
    while (n_acks != target && budget < 3000) begin
      @(posedge clk); #2;
      budget++;
      if (if_ack) if_req = 0;
      if (d_ack) d_req = 0;
    end
    if (n_acks != target) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: got %0d acks, expected %0d", n_acks, target);
      finish_run();
    end
  endtask

  task automatic issue(input bit do_f, input logic [31:0] faddr, input bit do_d, input bit we,
                       input logic [1:0] size, input bit sgn, input logic [31:0] daddr,
                       input logic [31:0] wdata, input bit tmo);
    entry_t ef, ed;
    bit first_d;
    first_d = (do_f && do_d) ? !last_d_m : do_d;
    if (first_d) begin
      ed = model_xact(1, we, size, sgn, daddr, wdata);
      ed.grant = cyc; ed.tmo = tmo;
      if (tmo) ed.exp_rdata = 0;
      sb.push_back(ed);
      if (do_f) begin ef = model_xact(0, 0, 2'd2, 0, faddr, 0); sb.push_back(ef); end
    end else begin
      ef = model_xact(0, 0, 2'd2, 0, faddr, 0);
      ef.grant = cyc;
      sb.push_back(ef);
      if (do_d) begin ed = model_xact(1, we, size, sgn, daddr, wdata); sb.push_back(ed); end
    end
    last_d_m = (do_f && do_d) ? !first_d : do_d;
    if_addr = faddr; if_req = do_f;
    d_we = we; d_size = size; d_signed = sgn; d_addr = daddr; d_wdata = wdata; d_req = do_d;
    run(n_acks + int'(do_f) + int'(do_d));
  endtask

  // Monitor (ack scoreboard) and Avalon slave share one negedge process.
  always @(negedge clk) begin
    entry_t e;
    int g, exp_c;
    bit ws;
    if (reset) begin
      stalls = 0; cur_st = 0; waitrequest = 0;
    end else begin
      if (if_ack || d_ack) begin
        check("ack_onehot", 32'(if_ack & d_ack), 32'd0);
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_ack: got if_ack=%0d d_ack=%0d, expected none", if_ack, d_ack);
        end else begin
          e = sb.pop_front();
          g = (e.grant < 0) ? last_ack + 1 : e.grant;
          check("ack_who", 32'(d_ack), 32'(e.is_data));
          check("err", 32'(err), 32'(e.mis | e.tmo));
          if (e.mis || e.tmo || !e.we)
            check(e.is_data ? "d_rdata" : "if_rdata", e.is_data ? d_rdata : if_rdata,
                  e.exp_rdata);
          exp_c = e.mis ? g + 1 : e.tmo ? g + 1 + int'(TMO) : g + 2 + stalls;
          check("latency", 32'(cyc), 32'(exp_c));
        end
        last_ack = cyc; stalls = 0; n_acks++;
      end
      if (read || write) begin
        if (sb.size() == 0 || sb[0].mis) begin
          n_tests++; n_fail++;
          $display("FAIL bus_unexpected: got read=%0d write=%0d, expected idle bus", read, write);
        end else begin
          e = sb[0];
          check("address", address, e.exp_addr);
          check("byteenable", 32'(byteenable), 32'(e.exp_be));
          check("rw_dir", 32'({read, write}), e.we ? 32'd1 : 32'd2);
          if (write) check("writedata", writedata, e.exp_wd);
        end
        ws = (stall_n < 0) ? ($urandom_range(0, 2) == 0) : (cur_st < stall_n);
        waitrequest = ws;
        readdata = smem[address[5:2]];
        if (ws) begin
          stalls++; cur_st++;
        end else begin
          cur_st = 0;
          if (write)
            for (int l = 0; l < 4; l++)
              if (byteenable[l]) smem[address[5:2]][8*l +: 8] = writedata[8*l +: 8];
        end
      end else begin
        cur_st = 0;
        waitrequest = 1'($urandom_range(0, 1));
        readdata = $urandom;
      end
    end
  end

  initial begin
    logic [31:0] tmp, fa, da;
    logic [1:0] sz;
    int kind, r;
    for (int w = 0; w < 16; w++) poke(w, $urandom);
    repeat (3) @(posedge clk);
    #2 reset = 0;
    check("rst_bus", address | writedata | 32'(byteenable), 32'd0);
    check("rst_ctrl", 32'({read, write, busy, if_ack, d_ack, err}), 32'd0);
    check("rst_rdata", if_rdata | d_rdata, 32'd0);

    stall_n = 0;
    poke(0, 32'h2402000A);
    issue(1, 32'hBFC0_0000, 0, 0, 2'd2, 0, 0, 0, 0);
    check("fetch_word", if_rdata, 32'h2402000A);
    poke(0, 32'h80FF1234);
    issue(0, 0, 1, 0, 2'd1, 1, 32'h2002, 0, 0);
    check("ld_half_s", d_rdata, 32'hFFFF80FF);
    issue(0, 0, 1, 0, 2'd1, 0, 32'h2002, 0, 0);
    check("ld_half_u", d_rdata, 32'h000080FF);
    stall_n = 3;
    issue(0, 0, 1, 1, 2'd0, 0, 32'h1003, 32'h0000_00AB, 0);
    stall_n = 0;
    issue(0, 0, 1, 0, 2'd2, 0, 32'h2001, 0, 0);

    // Reset while stalled in ACCESS abandons the bus cycle.
    stall_n = 1000;
    void'(model_xact(1, 0, 2'd2, 0, 32'h40, 0));
    sb.push_back(model_xact(1, 0, 2'd2, 0, 32'h40, 0));
    d_we = 0; d_size = 2'd2; d_addr = 32'h40; d_req = 1;
    r = 0;
    while (!read && r < 10) begin @(posedge clk); #2; r++; end
    check("rst_mid_read_seen", 32'(read), 32'd1);
    reset = 1; d_req = 0;
    @(posedge clk); #2;
    check("rst_mid_ctrl", 32'({read, write, busy, if_ack, d_ack}), 32'd0);
    sb.delete();
    reset = 0; last_d_m = 0;
    @(posedge clk); #2;
    check("rst_mid_idle", 32'({busy, if_ack, d_ack}), 32'd0);

    stall_n = 0;
    for (int i = 0; i < 4; i++)
      issue(1, 32'(4 * i), 1, 0, 2'd2, 0, 32'(4 * i + 16), 0, 0);

`ifdef MIPS_BUS_TIMEOUT_EN
    stall_n = 1000;
    issue(0, 0, 1, 0, 2'd2, 0, 32'h80, 0, 1);
`endif

    stall_n = -1;
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      tmp = $urandom;
      fa = {tmp[31:6], 6'($urandom_range(0, 63))};
      if ($urandom_range(0, 7) != 0) fa[1:0] = 2'b00;
      tmp = $urandom;
      da = {tmp[31:6], 6'($urandom_range(0, 63))};
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      issue(kind != 1, fa, kind != 0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            da, $urandom, 0);
    end

    for (int w = 0; w < 16; w++)
      check("mem_final", smem[w], {mmem[4*w+3], mmem[4*w+2], mmem[4*w+1], mmem[4*w]});
    check("sb_empty", 32'(sb.size()), 32'd0);
    finish_run();
  end

endmodule
